envelope_length: RTL and testbench

- Consumer end of the audio frame sequencer. Takes the 240 Hz quarter-frame and 120 Hz half-frame enable pulses and drives one tone channel's volume envelope and length counter.
- A small register-write interface, the CPU side, loads the control and length values.
- Output is a 4-bit volume for the channel mixer plus an active flag for status readback.

---
 rtl/envelope_length.sv | 114 +++++++++++
 tb/tb_envelope_length.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/envelope_length.sv
// ============================================================================
// envelope_length: volume envelope and length counter for one tone channel.
// Rev 1.0
// ============================================================================
`default_nettype none

module envelope_length (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_240hz,
  input  logic       enable_120hz,
  input  logic       ctrl_we,
  input  logic       length_we,
  input  logic [7:0] data,
  input  logic       channel_enable,
  output logic [3:0] volume,
  output logic       active
);

  logic       halt_q,      halt_d;
  logic       const_vol_q, const_vol_d;
  logic [3:0] period_q,    period_d;
  logic [7:0] length_q,    length_d;
  logic [3:0] decay_q,     decay_d;
  logic [3:0] divider_q,   divider_d;
  logic       start_q,     start_d;

  function automatic logic [7:0] length_lut(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
      5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
      5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
      5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
      5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
      5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
      5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   default: v = 8'd30;
    endcase
    return v;
  endfunction

  always_comb begin
    halt_d      = halt_q;
    const_vol_d = const_vol_q;
    period_d    = period_q;
    length_d    = length_q;
    decay_d     = decay_q;
    divider_d   = divider_q;
    start_d     = start_q;

    if (ctrl_we) begin
      halt_d      = data[5];
      const_vol_d = data[4];
      period_d    = data[3:0];
    end

    // Envelope step sees the pre-write start/halt/period values.
    if (enable_240hz) begin
      if (start_q) begin
        start_d   = 1'b0;
        decay_d   = 4'hF;
        divider_d = period_q;
      end else if (divider_q == 4'd0) begin
        divider_d = period_q;
        if (decay_q != 4'd0) begin
          decay_d = decay_q - 4'd1;
        end else if (halt_q) begin
          decay_d = 4'hF;
        end
      end else begin
        divider_d = divider_q - 4'd1;
      end
    end

    if (length_we) begin
      start_d = 1'b1;
    end

    if (!channel_enable) begin
      length_d = 8'd0;
    end else if (length_we) begin
      length_d = length_lut(data[7:3]);
    end else if (enable_120hz && (length_q != 8'd0) && !halt_q) begin
      length_d = length_q - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt_q      <= 1'b0;
      const_vol_q <= 1'b0;
      period_q    <= 4'd0;
      length_q    <= 8'd0;
      decay_q     <= 4'd0;
      divider_q   <= 4'd0;
      start_q     <= 1'b0;
    end else begin
      halt_q      <= halt_d;
      const_vol_q <= const_vol_d;
      period_q    <= period_d;
      length_q    <= length_d;
      decay_q     <= decay_d;
      divider_q   <= divider_d;
      start_q     <= start_d;
    end
  end

  assign active = (length_q != 8'd0);
  assign volume = (length_q == 8'd0) ? 4'd0 : (const_vol_q ? period_q : decay_q);

endmodule

`default_nettype wire

// File: tb/tb_envelope_length.sv
// ============================================================================
// tb_envelope_length: directed self-checking bench for envelope_length.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_envelope_length;

  logic       clk;
  logic       reset;
  logic       enable_240hz;
  logic       enable_120hz;
  logic       ctrl_we;
  logic       length_we;
  logic [7:0] data;
  logic       channel_enable;
  logic [3:0] volume;
  logic       active;

  int tests_run = 0;
  int tests_failed = 0;

  envelope_length dut (
    .clk            (clk),
    .reset          (reset),
    .enable_240hz   (enable_240hz),
    .enable_120hz   (enable_120hz),
    .ctrl_we        (ctrl_we),
    .length_we      (length_we),
    .data           (data),
    .channel_enable (channel_enable),
    .volume         (volume),
    .active         (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] exp_vol, input logic exp_act);
    tests_run++;
    assert (volume === exp_vol) else begin
      tests_failed++;
      $error("FAIL %s volume: observed %0h expected %0h", tag, volume, exp_vol);
    end
    tests_run++;
    assert (active === exp_act) else begin
      tests_failed++;
      $error("FAIL %s active: observed %0b expected %0b", tag, active, exp_act);
    end
  endtask

  // One clock cycle with the given strobes/ticks; outputs sampled 1ns after the edge.
  task automatic cyc(input logic cw, input logic lw, input logic [7:0] d,
                     input logic q, input logic h);
    @(negedge clk);
    ctrl_we = cw; length_we = lw; data = d; enable_240hz = q; enable_120hz = h;
    @(posedge clk);
    #1;
    ctrl_we = 1'b0; length_we = 1'b0; enable_240hz = 1'b0; enable_120hz = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable_240hz = 1'b0; enable_120hz = 1'b0;
    ctrl_we = 1'b0; length_we = 1'b0; data = 8'h00; channel_enable = 1'b1;

    // 1: reset and idle ticks
    #12;
    check("reset", 4'd0, 1'b0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, i[0]);
    check("idle_ticks", 4'd0, 1'b0);
    tests_run++;
    assert (!$isunknown({volume, active})) else begin
      tests_failed++;
      $error("FAIL idle_no_x: observed %b expected no X", {volume, active});
    end

    // 2: constant volume, length 254 counted down by half ticks
    cyc(1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h17, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h08, 1'b0, 1'b0);
    check("len_load", 4'd7, 1'b1);
    for (int i = 0; i < 253; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("len_253", 4'd7, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("len_254", 4'd0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("len_floor", 4'd0, 1'b0);

    // 3: decaying envelope, period 2, length 2
    cyc(1'b1, 1'b0, 8'h02, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h18, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("decay_q1", 4'd15, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("decay_q3", 4'd15, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("decay_q4", 4'd14, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("decay_h1", 4'd14, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("decay_h2", 4'd0, 1'b0);

    // 4: loop with halt, period 0
    cyc(1'b1, 1'b0, 8'h20, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h08, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("loop_t1", 4'd15, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("loop_t2", 4'd14, 1'b1);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("loop_t16", 4'd0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("loop_wrap", 4'd15, 1'b1);
    for (int i = 0; i < 260; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("halt_hold", 4'd15, 1'b1);

    // 5: length write together with both ticks, from a clean reset
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    cyc(1'b0, 1'b1, 8'h18, 1'b1, 1'b1);
    check("simul_load", 4'd0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("simul_restart", 4'd15, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("simul_h1", 4'd14, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("simul_h2", 4'd0, 1'b0);

    // ctrl write and tick in one cycle: tick uses old period (0)
    cyc(1'b0, 1'b1, 8'h08, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h05, 1'b1, 1'b0);
    check("ctrl_tick_old", 4'd14, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("ctrl_tick_new", 4'd13, 1'b1);

    // 6: async reset pulse between clock edges
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset", 4'd0, 1'b0);
    #1 reset = 1'b0;
    cyc(1'b0, 1'b1, 8'h08, 1'b0, 1'b0);
    check("post_reset_load", 4'd0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("post_reset_env", 4'd15, 1'b1);

    // 5b: channel disable wins over a same-cycle length write
    cyc(1'b1, 1'b0, 8'h13, 1'b0, 1'b0);
    check("const3", 4'd3, 1'b1);
    @(negedge clk); channel_enable = 1'b0;
    cyc(1'b0, 1'b1, 8'h08, 1'b0, 1'b0);
    check("disable_write", 4'd0, 1'b0);
    channel_enable = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("disable_after", 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
